// File: rtl/char_demux_pkg.sv
// Shared types and constants for the five-slot character demultiplexer.
package char_demux_pkg;

    localparam int NUM_SLOTS = 5;
    localparam int CHAR_W    = 3;
    localparam int SEL_W     = 3;

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_ROTATE = 2'd1,
        S_CLEAR  = 2'd2
    } state_t;

    // Slot 0 occupies the most significant field of the flat bus.
    function automatic int slot_off(input int idx, input int cw);
        return (NUM_SLOTS - 1 - idx) * cw;
    endfunction

endpackage

// File: rtl/char_demux5_rot_tick_gen.sv
// One-cycle tick every DIV cycles while run is high; the count restarts
// from zero whenever run drops, so no partial period is carried over.
module rot_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = run && (cnt == CW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!run || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/char_demux5.sv
// Five-slot registered character demultiplexer with addressed/auto-increment
// writes, sequential clear and optional rotation (CHAR_DEMUX_ROTATE_EN).
module char_demux5
    import char_demux_pkg::*;
#(
    parameter int CHAR_W  = char_demux_pkg::CHAR_W,
    parameter int ROT_DIV = 50_000_000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [CHAR_W-1:0]             wr_char,
    input  logic [SEL_W-1:0]              wr_sel,
    input  logic                          auto_inc,
    input  logic                          rot_en,
    input  logic                          clear_req,
    output logic [NUM_SLOTS*CHAR_W-1:0]   slots,
    output logic [SEL_W-1:0]              wr_ptr,
    output logic                          err
);

    state_t            state_q, state_d;
    logic [CHAR_W-1:0] slot_q [NUM_SLOTS];
    logic [2:0]        clr_idx;
    logic              tick;
    logic              acc;
    logic              clr_done;
    logic [SEL_W-1:0]  tgt;
    logic              tgt_ok;

`ifdef CHAR_DEMUX_ROTATE_EN
    assign wr_ready = (state_q == S_LOAD);

    rot_tick_gen #(
        .DIV (ROT_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (state_q == S_ROTATE),
        .tick  (tick)
    );
`else
    localparam int unused_rot_div = ROT_DIV;
    logic unused_rot_en;

    assign unused_rot_en = rot_en;
    assign wr_ready      = (state_q != S_CLEAR);
    assign tick          = 1'b0;
`endif

    // A clear request in the same cycle drops any write.
    assign acc      = wr_valid && wr_ready && !clear_req;
    assign clr_done = (state_q == S_CLEAR) && (clr_idx == 3'd4);
    assign tgt      = auto_inc ? wr_ptr : wr_sel;
    assign tgt_ok   = (tgt < SEL_W'(NUM_SLOTS));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD: begin
                if (clear_req) begin
                    state_d = S_CLEAR;
`ifdef CHAR_DEMUX_ROTATE_EN
                end else if (rot_en) begin
                    state_d = S_ROTATE;
`endif
                end
            end
            S_ROTATE: begin
                if (clear_req) begin
                    state_d = S_CLEAR;
                end else if (!rot_en) begin
                    state_d = S_LOAD;
                end
            end
            S_CLEAR: begin
                if (clr_idx == 3'd4) begin
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOAD;
            clr_idx <= '0;
            wr_ptr  <= '0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            clr_idx <= (state_q == S_CLEAR) ? clr_idx + 3'd1 : 3'd0;
            if (clr_done) begin
                wr_ptr <= '0;
                err    <= 1'b0;
            end else if (acc) begin
                if (auto_inc) begin
                    wr_ptr <= (wr_ptr == 3'd4) ? 3'd0 : wr_ptr + 3'd1;
                end else if (!tgt_ok) begin
                    err <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                slot_q[k] <= '0;
            end
        end else if (state_q == S_CLEAR) begin
            slot_q[clr_idx] <= '0;
        end else if (clear_req) begin
            // clear takes precedence over a coincident rotation step
        end else if (tick) begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                slot_q[k] <= slot_q[(k + 1) % NUM_SLOTS];
            end
        end else if (acc && tgt_ok) begin
            slot_q[tgt] <= wr_char;
        end
    end

    always_comb begin
        slots = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            slots[slot_off(k, CHAR_W) +: CHAR_W] = slot_q[k];
        end
    end

endmodule

// File: tb/tb_char_demux5.sv
// Directed bench for char_demux5 (ROT_DIV = 4); the rotate test is
// selected when CHAR_DEMUX_ROTATE_EN is defined, else the ignore test.
module tb_char_demux5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_char;
    logic [2:0]  wr_sel;
    logic        auto_inc;
    logic        rot_en;
    logic        clear_req;
    logic [14:0] slots;
    logic [2:0]  wr_ptr;
    logic        err;

    int checks = 0;
    int errors = 0;
    logic [14:0] exp_slots;

    char_demux5 #(
        .CHAR_W  (3),
        .ROT_DIV (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_char   (wr_char),
        .wr_sel    (wr_sel),
        .auto_inc  (auto_inc),
        .rot_en    (rot_en),
        .clear_req (clear_req),
        .slots     (slots),
        .wr_ptr    (wr_ptr),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic do_write(input logic ai, input logic [2:0] sel,
                            input logic [2:0] ch);
        wr_valid = 1'b1;
        auto_inc = ai;
        wr_sel   = sel;
        wr_char  = ch;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        wr_valid = 1'b0; wr_char = '0; wr_sel = '0;
        auto_inc = 1'b0; rot_en = 1'b0; clear_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (slots !== 15'h0000) begin
            errors++;
            $display("FAIL reset_slots got %h want %h", slots, 15'h0000);
        end
        checks++;
        if (wr_ptr !== 3'd0 || err !== 1'b0 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctl got ptr=%0d err=%b rdy=%b want 0 0 1",
                     wr_ptr, err, wr_ready);
        end
    endtask

    task automatic test_addr_write;
        do_write(1'b0, 3'd2, 3'b101);
        checks++;
        if (slots !== 15'b000_000_101_000_000) begin
            errors++;
            $display("FAIL addr_write got %b want %b", slots,
                     15'b000_000_101_000_000);
        end
        checks++;
        if (wr_ptr !== 3'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL addr_write_ctl got ptr=%0d err=%b want 0 0",
                     wr_ptr, err);
        end
    endtask

    task automatic test_auto_inc;
        for (int i = 1; i <= 6; i++) begin
            do_write(1'b1, 3'd0, 3'(i));
        end
        checks++;
        if (slots !== 15'b110_010_011_100_101) begin
            errors++;
            $display("FAIL auto_inc got %b want %b", slots,
                     15'b110_010_011_100_101);
        end
        checks++;
        if (wr_ptr !== 3'd1) begin
            errors++;
            $display("FAIL auto_inc_ptr got %0d want 1", wr_ptr);
        end
    endtask

    task automatic test_invalid_and_clear;
        do_write(1'b0, 3'd6, 3'd7);
        checks++;
        if (slots !== 15'b110_010_011_100_101 || err !== 1'b1) begin
            errors++;
            $display("FAIL invalid_sel got %b err=%b want %b err=1", slots,
                     err, 15'b110_010_011_100_101);
        end
        clear_req = 1'b1;
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (wr_ready !== 1'b0) begin
                errors++;
                $display("FAIL clear_busy cycle %0d got rdy=%b want 0",
                         i, wr_ready);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (wr_ready !== 1'b1 || slots !== 15'h0000) begin
            errors++;
            $display("FAIL clear_done got rdy=%b slots=%h want 1 0000",
                     wr_ready, slots);
        end
        checks++;
        if (err !== 1'b0 || wr_ptr !== 3'd0) begin
            errors++;
            $display("FAIL clear_ctl got err=%b ptr=%0d want 0 0", err, wr_ptr);
        end
    endtask

    task automatic load_12345;
        for (int i = 1; i <= 5; i++) begin
            do_write(1'b1, 3'd0, 3'(i));
        end
        checks++;
        if (slots !== 15'b001_010_011_100_101 || wr_ptr !== 3'd0) begin
            errors++;
            $display("FAIL load_12345 got %b ptr=%0d want %b ptr=0", slots,
                     wr_ptr, 15'b001_010_011_100_101);
        end
    endtask

`ifdef CHAR_DEMUX_ROTATE_EN
    task automatic test_rotate;
        rot_en = 1'b1;
        @(posedge clk);
        #1;
        wr_valid = 1'b1; auto_inc = 1'b0; wr_sel = 3'd0; wr_char = 3'd7;
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL rotate_ready got %b want 0", wr_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (slots !== 15'b001_010_011_100_101) begin
            errors++;
            $display("FAIL rotate_early got %b want %b", slots,
                     15'b001_010_011_100_101);
        end
        @(posedge clk);
        #1;
        checks++;
        if (slots !== 15'b010_011_100_101_001) begin
            errors++;
            $display("FAIL rotate_step1 got %b want %b", slots,
                     15'b010_011_100_101_001);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (slots !== 15'b011_100_101_001_010 || wr_ptr !== 3'd0) begin
            errors++;
            $display("FAIL rotate_step2 got %b ptr=%0d want %b ptr=0", slots,
                     wr_ptr, 15'b011_100_101_001_010);
        end
        wr_valid = 1'b0;
        rot_en   = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL rotate_exit got rdy=%b want 1", wr_ready);
        end
        exp_slots = 15'b011_100_101_001_010;
    endtask
`else
    task automatic test_rotate_ignored;
        rot_en = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (slots !== 15'b001_010_011_100_101 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL rot_ignored got %b rdy=%b want %b rdy=1", slots,
                     wr_ready, 15'b001_010_011_100_101);
        end
        do_write(1'b0, 3'd4, 3'd3);
        checks++;
        if (slots !== 15'b001_010_011_100_011) begin
            errors++;
            $display("FAIL rot_ignored_write got %b want %b", slots,
                     15'b001_010_011_100_011);
        end
        rot_en = 1'b0;
        exp_slots = 15'b001_010_011_100_011;
    endtask
`endif

    task automatic test_clear_collision;
        wr_valid = 1'b1; auto_inc = 1'b0; wr_sel = 3'd0; wr_char = 3'd0;
        clear_req = 1'b1;
        @(posedge clk);
        #1;
        wr_valid  = 1'b0;
        clear_req = 1'b0;
        checks++;
        if (slots !== exp_slots || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL collision got %b rdy=%b want %b rdy=0", slots,
                     wr_ready, exp_slots);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (slots !== 15'h0000 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset got %h rdy=%b want 0000 rdy=1",
                     slots, wr_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        exp_slots = '0;
        test_reset();
        test_addr_write();
        test_auto_inc();
        test_invalid_and_clear();
        load_12345();
`ifdef CHAR_DEMUX_ROTATE_EN
        test_rotate();
`else
        test_rotate_ignored();
`endif
        test_clear_collision();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
